// File: rtl/decode_issue_stage.sv
// decode_issue_stage: decodes 16-bit instructions, forwards operands and issues registered ALU bundles
module decode_issue_stage #(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_a,
    output logic [7:0]  out_b,
    output logic [2:0]  out_s,
    output logic [2:0]  out_rd,
    output logic [7:0]  out_br_off,
    input  logic [7:0]  ex_f,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [7:0]  wb_data,
    input  logic        flush
);
    logic [7:0] rf_q [NUM_REGS];
    logic [7:0] rf_d [NUM_REGS];
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_a_q, out_a_d, out_b_q, out_b_d, out_br_off_q, out_br_off_d;
    logic [2:0] out_s_q, out_s_d, out_rd_q, out_rd_d;
    logic [2:0] op, rd, rs1, rs2;
    logic       br, load, wb_wr;
    logic [7:0] a_val, b_val;

    assign op    = in_inst[15:13];
    assign rd    = in_inst[12:10];
    assign rs1   = in_inst[9:7];
    assign rs2   = in_inst[6:4];
    assign br    = op[2] & op[1];
    assign wb_wr = wb_en && wb_addr != 3'd0;

    assign in_ready = flush | ~out_valid_q | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    // EX forward beats WB bypass; out_rd is never 0 on a hit so R0 stays 0
    assign a_val = rs1 == 3'd0 ? 8'h00 :
                   (out_valid_q && out_rd_q == rs1) ? ex_f :
                   (wb_wr && wb_addr == rs1) ? wb_data : rf_q[rs1];
    assign b_val = rs2 == 3'd0 ? 8'h00 :
                   (out_valid_q && out_rd_q == rs2) ? ex_f :
                   (wb_wr && wb_addr == rs2) ? wb_data : rf_q[rs2];

    always_comb begin
        rf_d = rf_q;
        if (wb_wr) rf_d[wb_addr] = wb_data;
        out_valid_d  = flush ? 1'b0 : load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        out_a_d      = load ? a_val : out_a_q;
        out_b_d      = load ? b_val : out_b_q;
        out_s_d      = load ? op : out_s_q;
        out_rd_d     = load ? (br ? 3'd0 : rd) : out_rd_q;
        out_br_off_d = load ? (br ? {in_inst[12], rd, in_inst[3:0]} : 8'h00) : out_br_off_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q         <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_s_q      <= '0;
            out_rd_q     <= '0;
            out_br_off_q <= '0;
        end else begin
            rf_q         <= rf_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_s_q      <= out_s_d;
            out_rd_q     <= out_rd_d;
            out_br_off_q <= out_br_off_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_s      = out_s_q;
    assign out_rd     = out_rd_q;
    assign out_br_off = out_br_off_q;
endmodule
